// File: rtl/iir_coeff_ctrl.sv
// rtl/iir_coeff_ctrl.sv - shadow/active coefficient bank controller for a direct form I IIR filter
// Writes land in a shadow bank; a commit swaps the whole bank into the active ports at a sample boundary.

module iir_coeff_ctrl #(
    parameter int N            = 2,
    parameter int COEFF_WIDTH  = 16,
    parameter int Q            = 14,
    parameter int ADDR_WIDTH   = 4,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [COEFF_WIDTH-1:0]       wr_data,
    output logic                         wr_ready,
    input  logic                         commit,
    input  logic                         flush_en,
    input  logic                         abort,
    input  logic                         sample_strobe,
    output logic [COEFF_WIDTH*(N+1)-1:0] packed_b_coeffs,
    output logic [COEFF_WIDTH*N-1:0]     packed_a_coeffs,
    output logic                         filt_rst_n,
    output logic                         busy,
    output logic                         commit_done,
    output logic                         addr_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0]       FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [ADDR_WIDTH-1:0]  MAX_ADDR   = ADDR_WIDTH'(2 * N);
    localparam logic [COEFF_WIDTH-1:0] UNITY      = COEFF_WIDTH'(1) << Q;

    logic [1:0]             state_q, state_d;
    logic [COEFF_WIDTH-1:0] shadow_b_q [0:N];
    logic [COEFF_WIDTH-1:0] shadow_b_d [0:N];
    logic [COEFF_WIDTH-1:0] shadow_a_q [0:N-1];
    logic [COEFF_WIDTH-1:0] shadow_a_d [0:N-1];
    logic [COEFF_WIDTH-1:0] active_b_q [0:N];
    logic [COEFF_WIDTH-1:0] active_b_d [0:N];
    logic [COEFF_WIDTH-1:0] active_a_q [0:N-1];
    logic [COEFF_WIDTH-1:0] active_a_d [0:N-1];
    logic                   flush_flag_q, flush_flag_d;
    logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;
    logic                   filt_rst_n_q, filt_rst_n_d;
    logic                   addr_err_q, addr_err_d;

    always_comb begin
        state_d      = state_q;
        shadow_b_d   = shadow_b_q;
        shadow_a_d   = shadow_a_q;
        active_b_d   = active_b_q;
        active_a_d   = active_a_q;
        flush_flag_d = flush_flag_q;
        flush_cnt_d  = flush_cnt_q;
        addr_err_d   = addr_err_q;

        case (state_q)
            ST_IDLE: begin
                // A write in the same cycle as commit still lands and joins the committed set.
                if (wr_en) begin
                    if (wr_addr > MAX_ADDR) begin
                        addr_err_d = 1'b1;
                    end else begin
                        for (int i = 0; i <= N; i++) begin
                            if (wr_addr == ADDR_WIDTH'(i)) shadow_b_d[i] = wr_data;
                        end
                        for (int i = 0; i < N; i++) begin
                            if (wr_addr == ADDR_WIDTH'(N + 1 + i)) shadow_a_d[i] = wr_data;
                        end
                    end
                end
                if (commit) begin
                    state_d      = ST_ARMED;
                    flush_flag_d = flush_en;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (sample_strobe) begin
                    active_b_d = shadow_b_q;
                    active_a_d = shadow_a_q;
                    if (flush_flag_q) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q <= CNT_W'(1)) begin
                    state_d     = ST_DONE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                addr_err_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        // Registered so the filter reset is glitch-free and low for every FLUSH cycle.
        filt_rst_n_d = (state_d != ST_FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            flush_flag_q <= 1'b0;
            flush_cnt_q  <= '0;
            filt_rst_n_q <= 1'b0;
            addr_err_q   <= 1'b0;
            for (int i = 0; i <= N; i++) begin
                shadow_b_q[i] <= (i == 0) ? UNITY : '0;
                active_b_q[i] <= (i == 0) ? UNITY : '0;
            end
            for (int i = 0; i < N; i++) begin
                shadow_a_q[i] <= '0;
                active_a_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            flush_flag_q <= flush_flag_d;
            flush_cnt_q  <= flush_cnt_d;
            filt_rst_n_q <= filt_rst_n_d;
            addr_err_q   <= addr_err_d;
            shadow_b_q   <= shadow_b_d;
            shadow_a_q   <= shadow_a_d;
            active_b_q   <= active_b_d;
            active_a_q   <= active_a_d;
        end
    end

    always_comb begin
        packed_b_coeffs = '0;
        packed_a_coeffs = '0;
        for (int i = 0; i <= N; i++) begin
            packed_b_coeffs[COEFF_WIDTH*i +: COEFF_WIDTH] = active_b_q[i];
        end
        for (int i = 0; i < N; i++) begin
            packed_a_coeffs[COEFF_WIDTH*i +: COEFF_WIDTH] = active_a_q[i];
        end
    end

    assign wr_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_ARMED) || (state_q == ST_FLUSH);
    assign commit_done = (state_q == ST_DONE);
    assign filt_rst_n  = filt_rst_n_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// tb/tb_iir_coeff_ctrl.sv - scenario-task bench for iir_coeff_ctrl against a transaction-level model

module tb_iir_coeff_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        commit;
    logic        flush_en;
    logic        abort;
    logic        sample_strobe;
    logic [47:0] packed_b_coeffs;
    logic [31:0] packed_a_coeffs;
    logic        filt_rst_n;
    logic        busy;
    logic        commit_done;
    logic        addr_err;

    int checks;
    int fails;

    // Model: shadow/active coefficient banks indexed as in the register map
    logic [15:0] mb [0:2];
    logic [15:0] ma [0:1];
    logic [15:0] ab [0:2];
    logic [15:0] aa [0:1];
    logic        merr;

    iir_coeff_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .commit(commit), .flush_en(flush_en), .abort(abort),
        .sample_strobe(sample_strobe), .packed_b_coeffs(packed_b_coeffs),
        .packed_a_coeffs(packed_a_coeffs), .filt_rst_n(filt_rst_n), .busy(busy),
        .commit_done(commit_done), .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] exp_b();
        return {ab[2], ab[1], ab[0]};
    endfunction

    function automatic logic [31:0] exp_a();
        return {aa[1], aa[0]};
    endfunction

    task automatic model_reset();
        mb[0] = 16'h4000; mb[1] = 16'h0; mb[2] = 16'h0; ma[0] = 16'h0; ma[1] = 16'h0;
        ab[0] = 16'h4000; ab[1] = 16'h0; ab[2] = 16'h0; aa[0] = 16'h0; aa[1] = 16'h0;
        merr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = 4'(addr); wr_data = d;
        tick();
        wr_en = 1'b0;
        if (addr <= 2) mb[addr] = d;
        else if (addr <= 4) ma[addr-3] = d;
        else merr = 1'b1;
    endtask

    task automatic run_commit(input logic fl, input int wait_n);
        int lat;
        int low;
        commit = 1'b1; flush_en = fl;
        tick();
        commit = 1'b0; flush_en = 1'b0;
        checks++;
        if (busy !== 1'b1 || wr_ready !== 1'b0) begin
            fails++; $display("FAIL armed: busy=%b wr_ready=%b required 1/0", busy, wr_ready);
        end
        for (int k = 0; k < wait_n; k++) begin
            tick();
            checks++;
            if (packed_b_coeffs !== exp_b() || packed_a_coeffs !== exp_a() || busy !== 1'b1) begin
                fails++; $display("FAIL hold: b=%h a=%h busy=%b required b=%h a=%h busy=1",
                                  packed_b_coeffs, packed_a_coeffs, busy, exp_b(), exp_a());
            end
        end
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        ab = mb; aa = ma;
        checks++;
        if (packed_b_coeffs !== exp_b() || packed_a_coeffs !== exp_a()) begin
            fails++; $display("FAIL swap: b=%h a=%h required b=%h a=%h",
                              packed_b_coeffs, packed_a_coeffs, exp_b(), exp_a());
        end
        lat = 0; low = 0;
        while (commit_done !== 1'b1 && lat < 20) begin
            if (filt_rst_n === 1'b0) low++;
            tick();
            lat++;
        end
        checks++;
        if (lat !== (fl ? 3 : 0) || low !== (fl ? 3 : 0)) begin
            fails++; $display("FAIL done_latency: latency=%0d low=%0d required %0d", lat, low, fl ? 3 : 0);
        end
        tick();
        merr = 1'b0;
        checks++;
        if (wr_ready !== 1'b1 || commit_done !== 1'b0 || filt_rst_n !== 1'b1 || addr_err !== merr) begin
            fails++; $display("FAIL back_idle: wr_ready=%b done=%b frst=%b err=%b required 1/0/1/0",
                              wr_ready, commit_done, filt_rst_n, addr_err);
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if (packed_b_coeffs !== 48'h0000_0000_4000 || packed_a_coeffs !== 32'h0 || filt_rst_n !== 1'b0 ||
            busy !== 1'b0 || commit_done !== 1'b0 || addr_err !== 1'b0) begin
            fails++; $display("FAIL reset_values: b=%h a=%h frst=%b busy=%b done=%b err=%b required 4000/0/0/0/0/0",
                              packed_b_coeffs, packed_a_coeffs, filt_rst_n, busy, commit_done, addr_err);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (filt_rst_n !== 1'b1 || wr_ready !== 1'b1) begin
            fails++; $display("FAIL reset_release: frst=%b wr_ready=%b required 1/1", filt_rst_n, wr_ready);
        end
    endtask

    task automatic test_basic_commit();
        wr(0, 16'h1000); wr(1, 16'h2000); wr(2, 16'h1000); wr(3, 16'hC000); wr(4, 16'h0800);
        run_commit(1'b0, 10);
    endtask

    task automatic test_flush();
        wr(1, 16'($urandom)); wr(4, 16'($urandom));
        run_commit(1'b1, 2);
    endtask

    task automatic test_armed_abort();
        wr(2, 16'($urandom));
        commit = 1'b1; tick(); commit = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h7FFF; tick();
        wr_addr = 4'd7; tick();
        wr_en = 1'b0;
        checks++;
        if (addr_err !== 1'b0) begin
            fails++; $display("FAIL armed_addr_err: err=%b required 0", addr_err);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        checks++;
        if (wr_ready !== 1'b1 || busy !== 1'b0 || commit_done !== 1'b0 ||
            packed_b_coeffs !== exp_b() || packed_a_coeffs !== exp_a()) begin
            fails++; $display("FAIL abort: wr_ready=%b busy=%b done=%b b=%h required 1/0/0 b=%h",
                              wr_ready, busy, commit_done, packed_b_coeffs, exp_b());
        end
        tick();
        checks++;
        if (commit_done !== 1'b0) begin
            fails++; $display("FAIL abort_no_done: done=%b required 0", commit_done);
        end
        run_commit(1'b0, 1);
    endtask

    task automatic test_addr_err();
        wr(5, 16'($urandom));
        checks++;
        if (addr_err !== 1'b1) begin
            fails++; $display("FAIL addr_err_set: err=%b required 1", addr_err);
        end
        wr(2, 16'($urandom));
        run_commit(1'b0, 0);
    endtask

    task automatic test_abort_strobe();
        wr(3, 16'($urandom));
        commit = 1'b1; tick(); commit = 1'b0;
        abort = 1'b1; sample_strobe = 1'b1; tick();
        abort = 1'b0; sample_strobe = 1'b0;
        checks++;
        if (wr_ready !== 1'b1 || commit_done !== 1'b0 ||
            packed_b_coeffs !== exp_b() || packed_a_coeffs !== exp_a()) begin
            fails++; $display("FAIL abort_strobe: wr_ready=%b done=%b a=%h required 1/0 a=%h",
                              wr_ready, commit_done, packed_a_coeffs, exp_a());
        end
    endtask

    task automatic test_reset_mid_flush();
        commit = 1'b1; flush_en = 1'b1; tick(); commit = 1'b0; flush_en = 1'b0;
        sample_strobe = 1'b1; tick(); sample_strobe = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (filt_rst_n !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1 ||
            packed_b_coeffs !== exp_b() || packed_a_coeffs !== exp_a()) begin
            fails++; $display("FAIL reset_mid_flush: frst=%b busy=%b b=%h a=%h required 0/0 b=%h a=%h",
                              filt_rst_n, busy, packed_b_coeffs, packed_a_coeffs, exp_b(), exp_a());
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_commit(1'b0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int nw;
            nw = $urandom_range(1, 6);
            for (int w = 0; w < nw; w++) wr($urandom_range(0, 6), 16'($urandom));
            checks++;
            if (addr_err !== merr) begin
                fails++; $display("FAIL rand_err: err=%b required %b", addr_err, merr);
            end
            run_commit(1'($urandom_range(0, 1)), $urandom_range(0, 4));
        end
    endtask

    initial begin
        checks = 0; fails = 0;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; flush_en = 1'b0; abort = 1'b0; sample_strobe = 1'b0;
        test_reset();
        test_basic_commit();
        test_flush();
        test_armed_abort();
        test_addr_err();
        test_abort_strobe();
        test_reset_mid_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
